// File: rtl/prng_idx_sampler.sv
// Command-side sequencer for the LCG PRNG: seeds it, issues generate commands and
// reduces each 15-bit draw to a uniform index in [0, N) by mask-and-reject.
module prng_idx_sampler #(
  parameter int N        = 1000,
  parameter int IDX_W    = $clog2(N),
  parameter int PRNG_LAT = 7,
  parameter int SEED_LAT = 3,
  parameter int MAX_REJ  = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [31:0]      seed,
  input  logic [15:0]      num,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [1:0]       prng_typ_sel,
  output logic [31:0]      prng_t_dat,
  output logic             prng_t_sel,
  input  logic [31:0]      prng_r_dat,
  output logic             idx_vld,
  output logic [IDX_W-1:0] idx,
  input  logic             idx_rdy,
  output logic [15:0]      rej_cnt
);

  localparam logic [15:0] MASK = 16'((32'd1 << IDX_W) - 1);
  localparam logic [15:0] N_L  = 16'(N);

  typedef enum logic [3:0] {
    IDLE, LOAD, SEED, SEED_WAIT, REQ, WAIT, EVAL, OUT, DONE
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  lat_cnt;
  logic [15:0] num_q, emit_q, consec_q;
  logic [15:0] m;
  logic        accept, rej_last, emit_last;
  logic        unused_hi;

  assign unused_hi = ^prng_r_dat[31:15];

  // Only the low 15 bits carry PRNG entropy; the compare is unsigned.
  assign m         = {1'b0, prng_r_dat[14:0]} & MASK;
  assign accept    = m < N_L;
  assign rej_last  = (consec_q + 16'd1) == 16'(MAX_REJ);
  assign emit_last = (emit_q + 16'd1) == num_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (start) state_d = LOAD;
      LOAD:      state_d = SEED;
      SEED:      state_d = SEED_WAIT;
      SEED_WAIT: if (lat_cnt == 8'(SEED_LAT - 1)) state_d = (num_q == 16'd0) ? DONE : REQ;
      REQ:       state_d = WAIT;
      WAIT:      if (lat_cnt == 8'(PRNG_LAT - 1)) state_d = EVAL;
      EVAL:      state_d = accept ? OUT : (rej_last ? DONE : REQ);
      OUT:       if (idx_rdy) state_d = emit_last ? DONE : REQ;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      lat_cnt <= '0;
    end else begin
      state_q <= state_d;
      lat_cnt <= (state_d != state_q) ? 8'd0 : lat_cnt + 8'd1;
    end
  end

  // Job bookkeeping: counters, captured request, latched index and error flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      num_q      <= '0;
      emit_q     <= '0;
      consec_q   <= '0;
      rej_cnt    <= '0;
      err        <= 1'b0;
      idx        <= '0;
      prng_t_dat <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          num_q      <= num;
          prng_t_dat <= seed;
          emit_q     <= '0;
          consec_q   <= '0;
          rej_cnt    <= '0;
          err        <= 1'b0;
        end
        EVAL: if (accept) begin
          idx      <= m[IDX_W-1:0];
          consec_q <= '0;
        end else begin
          consec_q <= consec_q + 16'd1;
          if (rej_cnt != 16'hFFFF) rej_cnt <= rej_cnt + 16'd1;
          if (rej_last) err <= 1'b1;
        end
        OUT: if (idx_rdy) emit_q <= emit_q + 16'd1;
        default: ;
      endcase
    end
  end

  // Outputs are registered decodes of the next state so they align with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      idx_vld      <= 1'b0;
      prng_t_sel   <= 1'b0;
      prng_typ_sel <= 2'd0;
    end else begin
      busy         <= state_d != IDLE;
      done         <= state_d == DONE;
      idx_vld      <= state_d == OUT;
      prng_t_sel   <= state_d == LOAD;
      prng_typ_sel <= (state_d == SEED) ? 2'd2 : (state_d == REQ) ? 2'd1 : 2'd0;
    end
  end

endmodule
